// File: rtl/data_sram_ctrl_pkg.sv
// Shared types for the CPU data-port SRAM controller: FSM states, bus widths, lane helper.
// Pure declarations; no latency or backpressure of its own.
package data_sram_ctrl_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int SRAM_AW = 20;
  localparam int BE_W    = 4;
  localparam int CNT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WSETUP = 3'd2,
    ST_WPULSE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic [BE_W-1:0] sel_to_be_n(input logic [BE_W-1:0] sel);
    return ~sel;
  endfunction

endpackage

// File: rtl/data_sram_ctrl_if.sv
// CPU data-port bundle between the pipeline (master) and the SRAM controller (slave).
// Request held by the CPU while stallreq_o is high; read data returned on ram_data_o.
interface data_sram_ctrl_if;
  import data_sram_ctrl_pkg::*;

  logic              ram_ce_i;
  logic              ram_we_i;
  logic [BE_W-1:0]   ram_sel_i;
  logic [ADDR_W-1:0] ram_addr_i;
  logic [DATA_W-1:0] ram_data_i;
  logic [DATA_W-1:0] ram_data_o;
  logic              stallreq_o;

  modport master (
    output ram_ce_i, ram_we_i, ram_sel_i, ram_addr_i, ram_data_i,
    input  ram_data_o, stallreq_o
  );

  modport slave (
    input  ram_ce_i, ram_we_i, ram_sel_i, ram_addr_i, ram_data_i,
    output ram_data_o, stallreq_o
  );

endinterface

// File: rtl/data_sram_ctrl.sv
// Async SRAM controller for the CPU data port; read = 1+READ_CYCLES stall cycles, write = 2+WRITE_CYCLES,
// sel=0 write = 1. Backpressure: stallreq_o holds the pipeline until the access reaches DONE.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int unsigned READ_CYCLES  = 1,
  parameter int unsigned WRITE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  data_sram_ctrl_if.slave    cpu,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [DATA_W-1:0]  sram_data_o,
  input  logic [DATA_W-1:0]  sram_data_i,
  output logic               sram_data_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [BE_W-1:0]    sram_be_n
);

  localparam logic [CNT_W-1:0] RD_LOAD = READ_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] WR_LOAD = WRITE_CYCLES[CNT_W-1:0];

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [SRAM_AW-1:0]   sram_addr_q;
  logic [DATA_W-1:0]    sram_data_q;
  logic [DATA_W-1:0]    ram_data_q;
  logic                 data_oe_q;
  logic                 ce_n_q;
  logic                 oe_n_q;
  logic                 we_n_q;
  logic [BE_W-1:0]      be_n_q;

  // Byte offset and the top address bits never reach the 1M-word SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu.ram_addr_i[ADDR_W-1:SRAM_AW+2], cpu.ram_addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sram_addr_q <= '0;
      sram_data_q <= '0;
      ram_data_q  <= '0;
      data_oe_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= '1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu.ram_ce_i) begin
            sram_addr_q <= cpu.ram_addr_i[SRAM_AW+1:2];
            if (!cpu.ram_we_i) begin
              state_q <= ST_READ;
              ce_n_q  <= 1'b0;
              oe_n_q  <= 1'b0;
              be_n_q  <= '0;
              cnt_q   <= RD_LOAD;
            end else if (cpu.ram_sel_i != '0) begin
              state_q     <= ST_WSETUP;
              ce_n_q      <= 1'b0;
              be_n_q      <= sel_to_be_n(cpu.ram_sel_i);
              sram_data_q <= cpu.ram_data_i;
              data_oe_q   <= 1'b1;
            end else begin
              // Empty write: complete without touching the SRAM.
              state_q <= ST_DONE;
            end
          end
        end
        ST_READ: begin
          if (cnt_q == 3'd1) begin
            ram_data_q <= sram_data_i;
            oe_n_q     <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_WSETUP: begin
          we_n_q  <= 1'b0;
          cnt_q   <= WR_LOAD;
          state_q <= ST_WPULSE;
        end
        ST_WPULSE: begin
          if (cnt_q == 3'd1) begin
            // we_n rises alone; address, lanes and data stay driven for one hold cycle.
            we_n_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_DONE: begin
          ce_n_q    <= 1'b1;
          oe_n_q    <= 1'b1;
          we_n_q    <= 1'b1;
          be_n_q    <= '1;
          data_oe_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu.stallreq_o = !rst && cpu.ram_ce_i && (state_q != ST_DONE);
  assign cpu.ram_data_o = ram_data_q;

  assign sram_addr_o  = sram_addr_q;
  assign sram_data_o  = sram_data_q;
  assign sram_data_oe = data_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_be_n    = be_n_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: default timing instance plus a READ_CYCLES=3 instance.
module tb_data_sram_ctrl;
  import data_sram_ctrl_pkg::*;

  logic clk;
  logic rst;

  data_sram_ctrl_if cpu_a ();
  data_sram_ctrl_if cpu_b ();

  logic [19:0] addr_a, addr_b;
  logic [31:0] dout_a, dout_b, din_a, din_b;
  logic        doe_a, doe_b, ce_n_a, ce_n_b, oe_n_a, oe_n_b, we_n_a, we_n_b;
  logic [3:0]  be_n_a, be_n_b;

  data_sram_ctrl #(.READ_CYCLES(1), .WRITE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cpu(cpu_a.slave),
    .sram_addr_o(addr_a), .sram_data_o(dout_a), .sram_data_i(din_a), .sram_data_oe(doe_a),
    .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a), .sram_we_n(we_n_a), .sram_be_n(be_n_a)
  );

  data_sram_ctrl #(.READ_CYCLES(3), .WRITE_CYCLES(2)) dut_r3 (
    .clk(clk), .rst(rst), .cpu(cpu_b.slave),
    .sram_addr_o(addr_b), .sram_data_o(dout_b), .sram_data_i(din_b), .sram_data_oe(doe_b),
    .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b), .sram_be_n(be_n_b)
  );

  int total = 0;
  int bad   = 0;
  int stall_a = 0, oe_lo_a = 0, we_lo_a = 0, doe_hi_a = 0;
  int stall_b = 0, oe_lo_b = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    stall_a = 0; oe_lo_a = 0; we_lo_a = 0; doe_hi_a = 0;
    stall_b = 0; oe_lo_b = 0;
  endtask

  // Per-cycle sampling away from the active edge: duration counters and bus-safety invariants.
  always @(negedge clk) begin
    stall_a  += int'(cpu_a.stallreq_o);
    oe_lo_a  += int'(!oe_n_a);
    we_lo_a  += int'(!we_n_a);
    doe_hi_a += int'(doe_a);
    stall_b  += int'(cpu_b.stallreq_o);
    oe_lo_b  += int'(!oe_n_b);
    if (!rst) begin
      chk("no_we_oe_overlap", 32'(!we_n_a && !oe_n_a), 32'd0);
      chk("no_doe_during_oe", 32'(doe_a && !oe_n_a), 32'd0);
    end
  end

  initial begin
    rst = 1'b1;
    cpu_a.ram_ce_i = 1'b0; cpu_a.ram_we_i = 1'b0; cpu_a.ram_sel_i = 4'h0;
    cpu_a.ram_addr_i = 32'h0; cpu_a.ram_data_i = 32'h0;
    cpu_b.ram_ce_i = 1'b0; cpu_b.ram_we_i = 1'b0; cpu_b.ram_sel_i = 4'h0;
    cpu_b.ram_addr_i = 32'h0; cpu_b.ram_data_i = 32'h0;
    din_a = 32'h0; din_b = 32'h0;
    tick(); tick();

    // Reset values, and stall suppressed while rst is high even with a request present.
    cpu_a.ram_ce_i = 1'b1;
    #1;
    chk("rst_stall", 32'(cpu_a.stallreq_o), 32'd0);
    chk("rst_ce_n", 32'(ce_n_a), 32'd1);
    chk("rst_oe_n", 32'(oe_n_a), 32'd1);
    chk("rst_we_n", 32'(we_n_a), 32'd1);
    chk("rst_be_n", 32'(be_n_a), 32'hF);
    chk("rst_doe", 32'(doe_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'h0);
    chk("rst_dout", dout_a, 32'h0);
    chk("rst_rdata", cpu_a.ram_data_o, 32'h0);
    cpu_a.ram_ce_i = 1'b0;
    rst = 1'b0;
    tick();

    // Read 0x8000_0010, SRAM returns 0xDEADBEEF.
    clr_cnt();
    cpu_a.ram_ce_i = 1'b1; cpu_a.ram_we_i = 1'b0; cpu_a.ram_sel_i = 4'hF;
    cpu_a.ram_addr_i = 32'h8000_0010; din_a = 32'hDEAD_BEEF;
    #1;
    chk("rd_idle_stall", 32'(cpu_a.stallreq_o), 32'd1);
    tick();
    chk("rd_addr", 32'(addr_a), 32'h0000_0004);
    chk("rd_oe_n", 32'(oe_n_a), 32'd0);
    chk("rd_ce_n", 32'(ce_n_a), 32'd0);
    chk("rd_be_n", 32'(be_n_a), 32'h0);
    tick();
    chk("rd_capture", cpu_a.ram_data_o, 32'hDEAD_BEEF);
    chk("rd_done_stall", 32'(cpu_a.stallreq_o), 32'd0);
    chk("rd_done_oe_n", 32'(oe_n_a), 32'd1);
    cpu_a.ram_ce_i = 1'b0;
    din_a = 32'h0BAD_0BAD;
    tick();
    chk("rd_idle_ce_n", 32'(ce_n_a), 32'd1);
    chk("rd_stall_cycles", 32'(stall_a), 32'd2);
    chk("rd_oe_cycles", 32'(oe_lo_a), 32'd1);
    chk("rd_hold_rdata", cpu_a.ram_data_o, 32'hDEAD_BEEF);

    // Write 0x8000_0020 <= 0x12345678, sel 0011; inputs disturbed mid-access must be ignored.
    clr_cnt();
    cpu_a.ram_ce_i = 1'b1; cpu_a.ram_we_i = 1'b1; cpu_a.ram_sel_i = 4'b0011;
    cpu_a.ram_addr_i = 32'h8000_0020; cpu_a.ram_data_i = 32'h1234_5678;
    tick();
    chk("wr_setup_be_n", 32'(be_n_a), 32'hC);
    chk("wr_setup_dout", dout_a, 32'h1234_5678);
    chk("wr_setup_doe", 32'(doe_a), 32'd1);
    chk("wr_setup_we_n", 32'(we_n_a), 32'd1);
    chk("wr_addr", 32'(addr_a), 32'h0000_0008);
    tick();
    chk("wr_pulse1_we_n", 32'(we_n_a), 32'd0);
    cpu_a.ram_addr_i = 32'h8000_0FF0; cpu_a.ram_data_i = 32'hFFFF_FFFF; cpu_a.ram_sel_i = 4'hF;
    tick();
    chk("wr_pulse2_we_n", 32'(we_n_a), 32'd0);
    tick();
    chk("wr_hold_we_n", 32'(we_n_a), 32'd1);
    chk("wr_hold_doe", 32'(doe_a), 32'd1);
    chk("wr_hold_be_n", 32'(be_n_a), 32'hC);
    chk("wr_hold_addr", 32'(addr_a), 32'h0000_0008);
    chk("wr_hold_dout", dout_a, 32'h1234_5678);
    chk("wr_done_stall", 32'(cpu_a.stallreq_o), 32'd0);
    cpu_a.ram_ce_i = 1'b0;
    tick();
    chk("wr_idle_doe", 32'(doe_a), 32'd0);
    chk("wr_idle_be_n", 32'(be_n_a), 32'hF);
    chk("wr_stall_cycles", 32'(stall_a), 32'd4);
    chk("wr_we_cycles", 32'(we_lo_a), 32'd2);
    chk("wr_doe_cycles", 32'(doe_hi_a), 32'd4);
    chk("wr_rdata_kept", cpu_a.ram_data_o, 32'hDEAD_BEEF);

    // Write with no byte lanes: one stall cycle, no strobe.
    clr_cnt();
    cpu_a.ram_ce_i = 1'b1; cpu_a.ram_we_i = 1'b1; cpu_a.ram_sel_i = 4'b0000;
    cpu_a.ram_addr_i = 32'h8000_0030; cpu_a.ram_data_i = 32'h5555_AAAA;
    tick();
    chk("sel0_done_stall", 32'(cpu_a.stallreq_o), 32'd0);
    cpu_a.ram_ce_i = 1'b0;
    tick();
    chk("sel0_stall_cycles", 32'(stall_a), 32'd1);
    chk("sel0_we_cycles", 32'(we_lo_a), 32'd0);
    chk("sel0_oe_cycles", 32'(oe_lo_a), 32'd0);
    chk("sel0_doe_cycles", 32'(doe_hi_a), 32'd0);
    chk("sel0_rdata", cpu_a.ram_data_o, 32'hDEAD_BEEF);

    // Back-to-back read then write with the request line held high throughout.
    clr_cnt();
    cpu_a.ram_ce_i = 1'b1; cpu_a.ram_we_i = 1'b0; cpu_a.ram_addr_i = 32'h8000_0040;
    din_a = 32'hCAFE_F00D;
    tick();
    tick();
    chk("b2b_rd_capture", cpu_a.ram_data_o, 32'hCAFE_F00D);
    cpu_a.ram_we_i = 1'b1; cpu_a.ram_sel_i = 4'b1000;
    cpu_a.ram_addr_i = 32'h8000_0044; cpu_a.ram_data_i = 32'h9900_0000;
    tick();
    chk("b2b_idle_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("b2b_idle_stall", 32'(cpu_a.stallreq_o), 32'd1);
    tick();
    chk("b2b_wr_be_n", 32'(be_n_a), 32'h7);
    chk("b2b_wr_addr", 32'(addr_a), 32'h0000_0011);
    tick(); tick(); tick();
    chk("b2b_wr_done_state", 32'(dut.state_q), 32'(ST_DONE));
    cpu_a.ram_ce_i = 1'b0;
    tick();
    chk("b2b_stall_cycles", 32'(stall_a), 32'd6);
    chk("b2b_we_cycles", 32'(we_lo_a), 32'd2);
    chk("b2b_oe_cycles", 32'(oe_lo_a), 32'd1);

    // Reset asserted during the second WPULSE cycle aborts the write.
    cpu_a.ram_ce_i = 1'b1; cpu_a.ram_we_i = 1'b1; cpu_a.ram_sel_i = 4'hF;
    cpu_a.ram_addr_i = 32'h8000_0080; cpu_a.ram_data_i = 32'hAAAA_5555;
    tick(); tick(); tick();
    chk("abort_pre_we_n", 32'(we_n_a), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_stall", 32'(cpu_a.stallreq_o), 32'd0);
    tick();
    chk("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("abort_we_n", 32'(we_n_a), 32'd1);
    chk("abort_ce_n", 32'(ce_n_a), 32'd1);
    chk("abort_oe_n", 32'(oe_n_a), 32'd1);
    chk("abort_doe", 32'(doe_a), 32'd0);
    chk("abort_be_n", 32'(be_n_a), 32'hF);
    chk("abort_rdata", cpu_a.ram_data_o, 32'h0);
    chk("abort_rst_stall", 32'(cpu_a.stallreq_o), 32'd0);
    cpu_a.ram_ce_i = 1'b0;
    rst = 1'b0;
    tick();

    // READ_CYCLES=3 instance: capture must take the value present on the third oe cycle.
    clr_cnt();
    cpu_b.ram_ce_i = 1'b1; cpu_b.ram_we_i = 1'b0; cpu_b.ram_addr_i = 32'h0000_0004;
    tick();
    din_b = 32'h1111_1111;
    chk("r3_oe1", 32'(oe_n_b), 32'd0);
    chk("r3_addr", 32'(addr_b), 32'h0000_0001);
    tick();
    din_b = 32'h2222_2222;
    chk("r3_oe2", 32'(oe_n_b), 32'd0);
    chk("r3_no_early_capture", cpu_b.ram_data_o, 32'h0);
    tick();
    din_b = 32'h3333_3333;
    chk("r3_oe3", 32'(oe_n_b), 32'd0);
    tick();
    din_b = 32'h4444_4444;
    chk("r3_capture", cpu_b.ram_data_o, 32'h3333_3333);
    chk("r3_done_oe_n", 32'(oe_n_b), 32'd1);
    cpu_b.ram_ce_i = 1'b0;
    tick();
    chk("r3_stall_cycles", 32'(stall_b), 32'd4);
    chk("r3_oe_cycles", 32'(oe_lo_b), 32'd3);
    chk("r3_rdata_held", cpu_b.ram_data_o, 32'h3333_3333);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_sram_ctrl.md
DATA_SRAM_CTRL -- requirements
Module: data_sram_ctrl

Interface
REQ-001 SHALL have parameter READ_CYCLES, default 1: number of cycles oe_n is held low per read (1..7).
REQ-002 SHALL have parameter WRITE_CYCLES, default 2: number of cycles we_n is held low per write (1..7).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ram_ce_i  input  1  CPU data-port request valid.
REQ-006 SHALL have port ram_we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port ram_sel_i  input  4  byte lanes for a write; bit n = byte n.
REQ-008 SHALL have port ram_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port ram_data_i  input  32  CPU write data.
REQ-010 SHALL have port ram_data_o  output  32  read data returned to the CPU.
REQ-011 SHALL have port stallreq_o  output  1  pipeline stall request to ctrl.
REQ-012 SHALL have port sram_addr_o  output  20  SRAM word address.
REQ-013 SHALL have port sram_data_o, sram_data_i, sram_data_oe  out/in/out  32/32/1  split tri-state data bus.
REQ-014 SHALL have port sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low SRAM strobes.
REQ-015 SHALL have port sram_be_n  output  4  active-low byte enables.

Function
REQ-016 SHALL implement the states IDLE, READ, WSETUP, WPULSE and DONE, with one down-counter (3 bits) for strobe length.
REQ-017 In IDLE with ram_ce_i=1, SHALL register the request. It SHALL set sram_addr_o=ram_addr_i[21:2] and sram_ce_n=0.
REQ-018 From IDLE, a read SHALL go to READ with oe_n=0 and be_n=4'h0, and load the counter with READ_CYCLES.
REQ-019 From IDLE, a write with ram_sel_i!=0 SHALL go to WSETUP with be_n=~ram_sel_i, sram_data_o=ram_data_i and data_oe=1.
REQ-020 A write with ram_sel_i=4'b0000 SHALL go straight to DONE and SHALL produce no SRAM strobe.
REQ-021 WSETUP SHALL last 1 cycle, then go to WPULSE with we_n=0 for exactly WRITE_CYCLES cycles.
REQ-022 On leaving WPULSE, we_n SHALL rise while addr, be_n and data_oe stay held that edge. This gives 1 cycle of hold, entering DONE.
REQ-023 On the final READ cycle, SHALL capture sram_data_i into ram_data_o, then go to DONE.
REQ-024 In DONE, SHALL deassert all strobes and set data_oe=0. It SHALL then return to IDLE on the next edge.
REQ-025 ram_data_o SHALL hold its value until the next read capture.
REQ-026 stallreq_o SHALL be combinational: 1 when rst=0, ram_ce_i=1 and state!=DONE; otherwise 0.
REQ-027 Latency: stallreq_o SHALL be high for 1+READ_CYCLES cycles on a read, 1 cycle on a sel=0 write, and 2+WRITE_CYCLES cycles on any other write.
REQ-028 CPU request inputs SHALL be sampled only in IDLE. Changes in any other state SHALL be ignored.
REQ-029 A request still asserted in IDLE after DONE (pipeline held by another source) SHALL be re-executed. This is acceptable because accesses are idempotent.
REQ-030 sram_we_n and sram_oe_n SHALL never be low in the same cycle.
REQ-031 data_oe SHALL be 1 only in WSETUP, WPULSE and the hold edge.

Reset
REQ-032 With rst=1 at a clock edge, SHALL go to IDLE with these values: sram_ce_n=1, oe_n=1, we_n=1, be_n=4'hF, data_oe=0, sram_addr_o=0, sram_data_o=0, ram_data_o=0, counter=0.
REQ-033 Reset during WPULSE or READ SHALL abort the access at that edge, with no completion and no capture.
REQ-034 stallreq_o SHALL be 0 whenever rst=1.

Structure
REQ-035 State encodings and the bus-width macros (RegBus, DataAddrBus) SHALL live in the shared define.v.
REQ-036 SHALL be a single module with no sub-module, because the counter and FSM are small.
REQ-037 SHALL be instantiated beside genshinmips, driving its ram_data_i port, and its stallreq_o SHALL feed the ctrl mem stall path.

Verification
REQ-038 Read: with addr=0x8000_0010 and SRAM returning 0xDEADBEEF, sram_addr_o SHALL be 0x00004 and oe_n SHALL be low 1 cycle. Stall SHALL be high for 2 cycles and ram_data_o SHALL be 0xDEADBEEF in DONE.
REQ-039 Write: with addr=0x8000_0020, data=0x12345678 and sel=4'b0011, be_n SHALL be 4'b1100 and we_n SHALL be low exactly 2 cycles. Data SHALL be driven from WSETUP through the hold edge, and stall SHALL be high 4 cycles.
REQ-040 A sel=0 write SHALL cause no we_n pulse and 1 stall cycle, and ram_data_o SHALL be unchanged.
REQ-041 Back-to-back read then write SHALL show IDLE between them. we_n and oe_n SHALL never overlap and data_oe SHALL never be high during oe_n=0.
REQ-042 Asserting rst in the second WPULSE cycle SHALL give all strobes high, stallreq_o=0 and state IDLE on the next edge.
REQ-043 With READ_CYCLES=3, a read SHALL show oe_n low 3 cycles and stall high 4 cycles, with capture on the third cycle.
